alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- Reservation station for integer/branch/jump instructions in the out-of-order RISC-V core.
- Placed between dispatch and the ALU.
- Buffers dispatched instructions and snoops the common data buses (ALU and LSB result broadcasts) to wake up pending operands.
- Each cycle, issues the lowest-indexed entry with both operands ready to the ALU as a registered one-cycle alu_en pulse.

Parameters:
- RS_SIZE, 16: number of entries (power of two, ≥ 2).
- ROB_W, 4: ROB index width, matches the ROB position width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  global ready; when 0, all state holds.
- rollback  in  1  misprediction flush.
- disp_en  in  1  dispatch valid.
- disp_opcode  in  7  opcode.
- disp_funct3  in  3  funct3.
- disp_funct7  in  1  funct7 bit 5.
- disp_rs1_rdy  in  1  rs1 value valid.
- disp_rs1_val  in  32  rs1 value.
- disp_rs1_tag  in  ROB_W  producer ROB index of rs1 when not ready.
- disp_rs2_rdy, disp_rs2_val, disp_rs2_tag  in  1/32/ROB_W  same fields for rs2.
- disp_imm  in  32  immediate.
- disp_pc  in  32  instruction PC.
- disp_rob_pos  in  ROB_W  destination ROB index.
- rs_full  out  1  no free entry (combinational from valid bits).
- alu_cdb_en, alu_cdb_pos, alu_cdb_val  in  1/ROB_W/32  ALU broadcast.
- lsb_cdb_en, lsb_cdb_pos, lsb_cdb_val  in  1/ROB_W/32  load/store broadcast.
- alu_en  out  1  issue pulse to ALU.
- alu_opcode, alu_funct3, alu_funct7  out  7/3/1  issued instruction fields.
- alu_val1, alu_val2, alu_imm, alu_pc  out  32 each  issued operands.
- alu_rob_pos  out  ROB_W  issued destination ROB index.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all entries invalid; alu_en=0; all alu_* data outputs 0.
  - rs_full=0, since all entries are invalid.
- rdy=0: all state and outputs hold. alu_en is held and is consumed by the ALU once, at the first edge where rdy=1.
- rollback=1 (with rdy=1): at the edge, all entries are invalidated and alu_en=0. Dispatch and CDB input in the same cycle are ignored. Rollback overrides everything except reset.
- Dispatch:
  - When disp_en=1 and rs_full=0, write to the lowest-indexed free entry and set it valid.
  - disp_en=1 while rs_full=1 is a protocol violation. The instruction is dropped and a simulation assertion fires.
- Per-entry state: valid, opcode, funct3, funct7, imm, pc, rob_pos, q1_rdy, v1, t1, q2_rdy, v2, t2.
- Wakeup, applied each edge for each valid entry and each not-ready operand:
  - If alu_cdb_en && alu_cdb_pos==tag, capture alu_cdb_val and set ready.
  - Otherwise, if lsb_cdb_en && lsb_cdb_pos==tag, capture lsb_cdb_val and set ready.
  - If both buses match the same tag, take the ALU bus.
- Same-cycle dispatch forwarding: a dispatched operand with rdy=0 whose tag matches a CDB broadcast in the same cycle is written already ready with the broadcast value.
- Select and issue:
  - Combinationally, pick the lowest index with valid && q1_rdy && q2_rdy.
  - Wakeups in the current cycle are not visible to select. A woken entry becomes eligible the next cycle.
  - At the edge: alu_en=1, alu_* are loaded from that entry, and the entry is invalidated.
  - If nothing is ready: alu_en=0 and the alu_* data outputs hold their last value.
- Throughput and latency:
  - At most one issue per cycle.
  - A dispatch with both operands ready at edge N yields alu_en=1 after edge N+1.
- Simultaneous dispatch and issue: the dispatch slot is chosen from pre-edge valid bits. A slot freed by issue is reusable from the next cycle.
- rs_full is valid bits all 1; it does not account for an issue in the same cycle.

Optional Feature:
- Macro: ALU_RS_BYPASS_EN.
- Defined:
  - Condition: disp_en=1, both dispatched operands ready (including via same-cycle CDB forwarding), and no stored entry ready this cycle.
  - Action: the instruction goes straight to the alu_* registers at edge N, giving alu_en=1 after edge N. No entry is allocated, even when rs_full=1.
- Undefined: every instruction goes through an entry, with minimum 2-edge latency.

Test Plan:
- Reset with rst_n low mid-operation, 3 entries valid → alu_en=0 and rs_full=0 immediately (asynchronous). After release, dispatching addi (imm=5, rs1 ready=10, rob_pos=3) → alu_en=1 one cycle after the write, with alu_val1=10, alu_imm=5, alu_rob_pos=3.
- Dispatch add with rs1 tag 2 not ready and rs2=7 → no issue. alu_cdb_en=1, pos=2, val=0x100 → entry issues the following cycle with alu_val1=0x100, alu_val2=7.
- Dispatch with rs2 tag 5 in the same cycle as lsb_cdb_en pos=5 val=0xdead → operand captured, issue with alu_val2=0xdead. Also drive the ALU and LSB buses on the same tag 6 with values 1 and 2 → the ALU value 1 is captured.
- Fill 16 entries, all waiting on tag 9 → rs_full=1. Broadcast tag 9 → entries issue in index order 0..15, one per cycle, and rs_full drops after the first issue.
- Rollback with 4 entries valid and alu_en pending → next cycle all entries are invalid and alu_en=0, and a dispatch presented in the rollback cycle is discarded.
- Hold rdy=0 for 3 cycles with a ready entry → alu_en and state are frozen, and exactly one issue occurs after rdy returns. With ALU_RS_BYPASS_EN and an empty RS, dispatch of a ready lui → alu_en=1 after 1 edge.

Source files
------------

// File: rtl/alu_rs.sv
// alu_rs: reservation station between dispatch and the ALU.
// Buffers integer/branch/jump instructions, wakes pending operands by
// snooping the ALU and LSB result buses, and issues the lowest-indexed
// entry whose operands are both ready as a registered one-cycle alu_en pulse.
// Optional build macro ALU_RS_BYPASS_EN: a dispatched instruction with both
// operands ready goes straight to the ALU output registers when no stored
// entry is ready, skipping entry allocation.
module alu_rs #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              rollback,
  input  logic              disp_en,
  input  logic [6:0]        disp_opcode,
  input  logic [2:0]        disp_funct3,
  input  logic              disp_funct7,
  input  logic              disp_rs1_rdy,
  input  logic [31:0]       disp_rs1_val,
  input  logic [ROB_W-1:0]  disp_rs1_tag,
  input  logic              disp_rs2_rdy,
  input  logic [31:0]       disp_rs2_val,
  input  logic [ROB_W-1:0]  disp_rs2_tag,
  input  logic [31:0]       disp_imm,
  input  logic [31:0]       disp_pc,
  input  logic [ROB_W-1:0]  disp_rob_pos,
  output logic              rs_full,
  input  logic              alu_cdb_en,
  input  logic [ROB_W-1:0]  alu_cdb_pos,
  input  logic [31:0]       alu_cdb_val,
  input  logic              lsb_cdb_en,
  input  logic [ROB_W-1:0]  lsb_cdb_pos,
  input  logic [31:0]       lsb_cdb_val,
  output logic              alu_en,
  output logic [6:0]        alu_opcode,
  output logic [2:0]        alu_funct3,
  output logic              alu_funct7,
  output logic [31:0]       alu_val1,
  output logic [31:0]       alu_val2,
  output logic [31:0]       alu_imm,
  output logic [31:0]       alu_pc,
  output logic [ROB_W-1:0]  alu_rob_pos
);

  localparam int IDX_W = $clog2(RS_SIZE);

  // Snoop both result buses for a tag; the ALU bus wins when both match.
  // Returns {hit, value}.
  function automatic logic [32:0] cdb_snoop(
    input logic [ROB_W-1:0] tag,
    input logic             a_en,
    input logic [ROB_W-1:0] a_pos,
    input logic [31:0]      a_val,
    input logic             l_en,
    input logic [ROB_W-1:0] l_pos,
    input logic [31:0]      l_val
  );
    logic [32:0] res;
    res = '0;
    if (a_en && (a_pos == tag)) begin
      res = {1'b1, a_val};
    end else if (l_en && (l_pos == tag)) begin
      res = {1'b1, l_val};
    end
    return res;
  endfunction

  // Entry storage: control bits plus payload.
  logic [RS_SIZE-1:0] r_valid;
  logic [RS_SIZE-1:0] r_q1_rdy;
  logic [RS_SIZE-1:0] r_q2_rdy;
  logic [6:0]         r_opcode  [RS_SIZE];
  logic [2:0]         r_funct3  [RS_SIZE];
  logic               r_funct7  [RS_SIZE];
  logic [31:0]        r_imm     [RS_SIZE];
  logic [31:0]        r_pc      [RS_SIZE];
  logic [ROB_W-1:0]   r_rob_pos [RS_SIZE];
  logic [31:0]        r_v1      [RS_SIZE];
  logic [ROB_W-1:0]   r_t1      [RS_SIZE];
  logic [31:0]        r_v2      [RS_SIZE];
  logic [ROB_W-1:0]   r_t2      [RS_SIZE];

  logic               w_full;
  logic [IDX_W-1:0]   w_free_idx;
  logic [RS_SIZE-1:0] w_ready_vec;
  logic               w_sel_found;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [32:0]        w_s1 [RS_SIZE];
  logic [32:0]        w_s2 [RS_SIZE];
  logic [32:0]        w_d1_snoop;
  logic [32:0]        w_d2_snoop;
  logic               w_d1_rdy;
  logic [31:0]        w_d1_val;
  logic               w_d2_rdy;
  logic [31:0]        w_d2_val;
  logic               w_bypass;
  logic               w_do_disp;
  logic [RS_SIZE-1:0] w_valid_nxt;

  assign w_full      = &r_valid;
  assign rs_full     = w_full;
  assign w_ready_vec = r_valid & r_q1_rdy & r_q2_rdy;
  assign w_sel_found = |w_ready_vec;

  // Lowest-indexed free slot and lowest-indexed issuable entry.
  always_comb begin
    w_free_idx = '0;
    w_sel_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_idx = IDX_W'(i);
      end
      if (w_ready_vec[i]) begin
        w_sel_idx = IDX_W'(i);
      end
    end
  end

  // Per-entry bus snoop results used for operand wakeup.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_s1[i] = cdb_snoop(r_t1[i], alu_cdb_en, alu_cdb_pos, alu_cdb_val,
                          lsb_cdb_en, lsb_cdb_pos, lsb_cdb_val);
      w_s2[i] = cdb_snoop(r_t2[i], alu_cdb_en, alu_cdb_pos, alu_cdb_val,
                          lsb_cdb_en, lsb_cdb_pos, lsb_cdb_val);
    end
  end

  // A dispatched operand that is broadcast this very cycle enters ready.
  assign w_d1_snoop = cdb_snoop(disp_rs1_tag, alu_cdb_en, alu_cdb_pos, alu_cdb_val,
                                lsb_cdb_en, lsb_cdb_pos, lsb_cdb_val);
  assign w_d2_snoop = cdb_snoop(disp_rs2_tag, alu_cdb_en, alu_cdb_pos, alu_cdb_val,
                                lsb_cdb_en, lsb_cdb_pos, lsb_cdb_val);
  assign w_d1_rdy   = disp_rs1_rdy | w_d1_snoop[32];
  assign w_d1_val   = disp_rs1_rdy ? disp_rs1_val : w_d1_snoop[31:0];
  assign w_d2_rdy   = disp_rs2_rdy | w_d2_snoop[32];
  assign w_d2_val   = disp_rs2_rdy ? disp_rs2_val : w_d2_snoop[31:0];

`ifdef ALU_RS_BYPASS_EN
  assign w_bypass = disp_en && w_d1_rdy && w_d2_rdy && !w_sel_found;
`else
  assign w_bypass = 1'b0;
`endif

  // The free slot comes from pre-edge valid bits, so a slot freed by this
  // cycle's issue is only reused next cycle.
  assign w_do_disp = disp_en && !w_full && !w_bypass;

  // Next valid vector: drop the issued entry, claim the free slot.
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_sel_found) begin
      w_valid_nxt[w_sel_idx] = 1'b0;
    end
    if (w_do_disp) begin
      w_valid_nxt[w_free_idx] = 1'b1;
    end
  end

  // Valid bits and the registered issue port; rollback clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= '0;
      alu_en      <= 1'b0;
      alu_opcode  <= '0;
      alu_funct3  <= '0;
      alu_funct7  <= 1'b0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rob_pos <= '0;
    end else if (rdy) begin
      if (rollback) begin
        r_valid <= '0;
        alu_en  <= 1'b0;
      end else begin
        r_valid <= w_valid_nxt;
        if (w_sel_found) begin
          alu_en      <= 1'b1;
          alu_opcode  <= r_opcode[w_sel_idx];
          alu_funct3  <= r_funct3[w_sel_idx];
          alu_funct7  <= r_funct7[w_sel_idx];
          alu_val1    <= r_v1[w_sel_idx];
          alu_val2    <= r_v2[w_sel_idx];
          alu_imm     <= r_imm[w_sel_idx];
          alu_pc      <= r_pc[w_sel_idx];
          alu_rob_pos <= r_rob_pos[w_sel_idx];
        end else if (w_bypass) begin
          alu_en      <= 1'b1;
          alu_opcode  <= disp_opcode;
          alu_funct3  <= disp_funct3;
          alu_funct7  <= disp_funct7;
          alu_val1    <= w_d1_val;
          alu_val2    <= w_d2_val;
          alu_imm     <= disp_imm;
          alu_pc      <= disp_pc;
          alu_rob_pos <= disp_rob_pos;
        end else begin
          alu_en <= 1'b0;
        end
      end
    end
  end

  // Entry payload: operand wakeup from the buses and dispatch writes.
  always_ff @(posedge clk) begin
    if (rdy && !rollback) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_valid[i] && !r_q1_rdy[i] && w_s1[i][32]) begin
          r_q1_rdy[i] <= 1'b1;
          r_v1[i]     <= w_s1[i][31:0];
        end
        if (r_valid[i] && !r_q2_rdy[i] && w_s2[i][32]) begin
          r_q2_rdy[i] <= 1'b1;
          r_v2[i]     <= w_s2[i][31:0];
        end
      end
      if (w_do_disp) begin
        r_opcode[w_free_idx]  <= disp_opcode;
        r_funct3[w_free_idx]  <= disp_funct3;
        r_funct7[w_free_idx]  <= disp_funct7;
        r_imm[w_free_idx]     <= disp_imm;
        r_pc[w_free_idx]      <= disp_pc;
        r_rob_pos[w_free_idx] <= disp_rob_pos;
        r_q1_rdy[w_free_idx]  <= w_d1_rdy;
        r_v1[w_free_idx]      <= w_d1_val;
        r_t1[w_free_idx]      <= disp_rs1_tag;
        r_q2_rdy[w_free_idx]  <= w_d2_rdy;
        r_v2[w_free_idx]      <= w_d2_val;
        r_t2[w_free_idx]      <= disp_rs2_tag;
      end
    end
  end

`ifndef SYNTHESIS
  // Dispatching into a full station drops the instruction.
  a_disp_when_full: assert property (
    @(posedge clk) disable iff (!rst_n)
    (rdy && !rollback && disp_en && w_full) |-> w_bypass
  ) else $error("alu_rs: dispatch while full, instruction dropped");
`endif

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: scoreboard bench for alu_rs. A behavioural model predicts each
// issue and queues it; a monitor pops and compares on every new alu_en pulse.
module tb_alu_rs;
  localparam int N = 16;
`ifdef ALU_RS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, rollback = 1'b0;
  logic        disp_en = 1'b0;
  logic [6:0]  disp_opcode = '0;
  logic [2:0]  disp_funct3 = '0;
  logic        disp_funct7 = 1'b0;
  logic        disp_rs1_rdy = 1'b0, disp_rs2_rdy = 1'b0;
  logic [31:0] disp_rs1_val = '0, disp_rs2_val = '0, disp_imm = '0, disp_pc = '0;
  logic [3:0]  disp_rs1_tag = '0, disp_rs2_tag = '0, disp_rob_pos = '0;
  logic        rs_full;
  logic        alu_cdb_en = 1'b0, lsb_cdb_en = 1'b0;
  logic [3:0]  alu_cdb_pos = '0, lsb_cdb_pos = '0;
  logic [31:0] alu_cdb_val = '0, lsb_cdb_val = '0;
  logic        alu_en;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;

  alu_rs #(.RS_SIZE(N), .ROB_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .disp_en(disp_en), .disp_opcode(disp_opcode), .disp_funct3(disp_funct3),
    .disp_funct7(disp_funct7), .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_val(disp_rs1_val),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_val(disp_rs2_val),
    .disp_rs2_tag(disp_rs2_tag), .disp_imm(disp_imm), .disp_pc(disp_pc),
    .disp_rob_pos(disp_rob_pos), .rs_full(rs_full),
    .alu_cdb_en(alu_cdb_en), .alu_cdb_pos(alu_cdb_pos), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_en(lsb_cdb_en), .lsb_cdb_pos(lsb_cdb_pos), .lsb_cdb_val(lsb_cdb_val),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
    .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm, pc;
    logic [3:0]  rob;
    bit          r1;
    logic [31:0] v1;
    logic [3:0]  t1;
    bit          r2;
    logic [31:0] v2;
    logic [3:0]  t2;
  } ent_t;

  typedef struct {
    logic [142:0] fields;
    int           stamp;
  } rec_t;

  ent_t m_ent[N];
  rec_t sb[$];
  rec_t mon_e;
  int   total = 0, bad = 0, edge_cnt = 0;
  bit   m_last_rdy = 1'b0;
  logic [142:0] mon_act;

  function automatic logic [142:0] pack(input logic [6:0] op, input logic [2:0] f3,
      input logic f7, input logic [31:0] v1, input logic [31:0] v2,
      input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
    return {op, f3, f7, v1, v2, imm, pc, rob};
  endfunction

  // Which broadcast (if any) carries this tag; the ALU bus wins.
  function automatic bit cdb_hit(input logic [3:0] tag, output logic [31:0] val);
    val = '0;
    if (alu_cdb_en && alu_cdb_pos == tag) begin val = alu_cdb_val; return 1'b1; end
    if (lsb_cdb_en && lsb_cdb_pos == tag) begin val = lsb_cdb_val; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_ent[i].v) c++;
    return c;
  endfunction

  // One clock edge of the reservation station described as entry operations.
  task automatic model_step();
    int sel = -1, free = -1;
    bit d1r, d2r, byp;
    logic [31:0] d1v, d2v, x;
    for (int i = 0; i < N; i++) begin
      if (sel < 0 && m_ent[i].v && m_ent[i].r1 && m_ent[i].r2) sel = i;
      if (free < 0 && !m_ent[i].v) free = i;
    end
    if (rollback) begin
      for (int i = 0; i < N; i++) m_ent[i].v = 1'b0;
      return;
    end
    d1r = disp_rs1_rdy; d1v = disp_rs1_val;
    if (!d1r && cdb_hit(disp_rs1_tag, x)) begin d1r = 1'b1; d1v = x; end
    d2r = disp_rs2_rdy; d2v = disp_rs2_val;
    if (!d2r && cdb_hit(disp_rs2_tag, x)) begin d2r = 1'b1; d2v = x; end
    byp = BYP && disp_en && d1r && d2r && (sel < 0);
    if (sel >= 0) begin
      sb.push_back('{pack(m_ent[sel].op, m_ent[sel].f3, m_ent[sel].f7, m_ent[sel].v1,
                          m_ent[sel].v2, m_ent[sel].imm, m_ent[sel].pc, m_ent[sel].rob), edge_cnt});
      m_ent[sel].v = 1'b0;
    end else if (byp) begin
      sb.push_back('{pack(disp_opcode, disp_funct3, disp_funct7, d1v, d2v, disp_imm,
                          disp_pc, disp_rob_pos), edge_cnt});
    end
    for (int i = 0; i < N; i++) begin
      if (m_ent[i].v && !m_ent[i].r1 && cdb_hit(m_ent[i].t1, x)) begin m_ent[i].r1 = 1'b1; m_ent[i].v1 = x; end
      if (m_ent[i].v && !m_ent[i].r2 && cdb_hit(m_ent[i].t2, x)) begin m_ent[i].r2 = 1'b1; m_ent[i].v2 = x; end
    end
    if (disp_en && free >= 0 && !byp) begin
      m_ent[free] = '{1'b1, disp_opcode, disp_funct3, disp_funct7, disp_imm, disp_pc,
                      disp_rob_pos, d1r, d1v, disp_rs1_tag, d2r, d2v, disp_rs2_tag};
    end
  endtask

  // Reference model advances on every clock edge outside reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_ent[i].v = 1'b0;
      sb.delete();
      m_last_rdy = 1'b0;
    end else begin
      edge_cnt++;
      m_last_rdy = rdy;
      if (rdy) model_step();
    end
  end

  // Monitor: occupancy every cycle, issue contents on each fresh pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (rs_full !== (m_count() == N)) begin
        bad++;
        $display("FAIL rs_full act=%b exp=%b edge=%0d", rs_full, (m_count() == N), edge_cnt);
      end
      if (m_last_rdy) begin
        total++;
        if (alu_en === 1'b1) begin
          mon_act = pack(alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos);
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_issue act=%h exp=none edge=%0d", mon_act, edge_cnt);
          end else begin
            mon_e = sb.pop_front();
            if (mon_act !== mon_e.fields || mon_e.stamp != edge_cnt) begin
              bad++;
              $display("FAIL issue act=%h exp=%h edge=%0d exp_edge=%0d", mon_act, mon_e.fields, edge_cnt, mon_e.stamp);
            end
          end
        end else if (sb.size() != 0 && sb[0].stamp <= edge_cnt) begin
          bad++;
          $display("FAIL missed_issue act=alu_en0 exp=%h edge=%0d", sb[0].fields, edge_cnt);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    disp_en = 1'b0; alu_cdb_en = 1'b0; lsb_cdb_en = 1'b0; rollback = 1'b0;
  endtask

  task automatic dsp(input logic [6:0] op, input logic [2:0] f3, input logic f7,
      input logic r1, input logic [31:0] v1, input logic [3:0] t1,
      input logic r2, input logic [31:0] v2, input logic [3:0] t2,
      input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
    disp_en = 1'b1; disp_opcode = op; disp_funct3 = f3; disp_funct7 = f7;
    disp_rs1_rdy = r1; disp_rs1_val = v1; disp_rs1_tag = t1;
    disp_rs2_rdy = r2; disp_rs2_val = v2; disp_rs2_tag = t2;
    disp_imm = imm; disp_pc = pc; disp_rob_pos = rob;
  endtask

  localparam logic [6:0] OP_ADDI = 7'b0010011, OP_ADD = 7'b0110011, OP_LUI = 7'b0110111;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Asynchronous reset mid-operation.
    for (int i = 1; i <= 3; i++) begin
      dsp(OP_ADD, 3'd0, 1'b0, 1'b0, 32'd0, 4'd15, 1'b1, 32'h11, 4'd0, 32'd0, 32'h1000 + 32'(4 * i), 4'(i));
      tick();
    end
    dsp(OP_ADDI, 3'd0, 1'b0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd0, 4'd0, 32'd1, 32'h1010, 4'd4);
    tick();
    repeat (BYP ? 0 : 1) tick();
    chk("pre_rst_alu_en", 32'(alu_en), 32'd1);
    #6 rst_n = 1'b0;
    #1;
    chk("rst_alu_en", 32'(alu_en), 32'd0);
    chk("rst_rs_full", 32'(rs_full), 32'd0);
    chk("rst_alu_val1", alu_val1, 32'd0);
    chk("rst_alu_imm", alu_imm, 32'd0);
    chk("rst_alu_rob_pos", 32'(alu_rob_pos), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // addi with rs1 ready.
    dsp(OP_ADDI, 3'd0, 1'b0, 1'b1, 32'd10, 4'd0, 1'b1, 32'd0, 4'd0, 32'd5, 32'h2000, 4'd3);
    tick();
    chk("addi_en_at_write", 32'(alu_en), 32'(BYP));
    tick();
    chk("addi_en_next", 32'(alu_en), 32'(!BYP));
    chk("addi_val1", alu_val1, 32'd10);
    chk("addi_imm", alu_imm, 32'd5);
    chk("addi_rob", 32'(alu_rob_pos), 32'd3);

    // add waiting on tag 2, woken by the ALU bus.
    dsp(OP_ADD, 3'd0, 1'b0, 1'b0, 32'd0, 4'd2, 1'b1, 32'd7, 4'd0, 32'd0, 32'h2004, 4'd4);
    tick();
    tick();
    chk("add_waiting", 32'(alu_en), 32'd0);
    alu_cdb_en = 1'b1; alu_cdb_pos = 4'd2; alu_cdb_val = 32'h100;
    tick();
    chk("wake_not_visible", 32'(alu_en), 32'd0);
    tick();
    chk("wake_issue_en", 32'(alu_en), 32'd1);
    chk("wake_val1", alu_val1, 32'h100);
    chk("wake_val2", alu_val2, 32'd7);

    // Same-cycle LSB forward into dispatch.
    dsp(OP_ADD, 3'd0, 1'b1, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd5, 32'd0, 32'h2008, 4'd5);
    lsb_cdb_en = 1'b1; lsb_cdb_pos = 4'd5; lsb_cdb_val = 32'hdead;
    tick();
    tick();
    chk("fwd_val2", alu_val2, 32'hdead);
    chk("fwd_rob", 32'(alu_rob_pos), 32'd5);

    // Both buses on tag 6: ALU value wins.
    dsp(OP_ADD, 3'd0, 1'b0, 1'b0, 32'd0, 4'd6, 1'b1, 32'd3, 4'd0, 32'd0, 32'h200c, 4'd6);
    tick();
    alu_cdb_en = 1'b1; alu_cdb_pos = 4'd6; alu_cdb_val = 32'd1;
    lsb_cdb_en = 1'b1; lsb_cdb_pos = 4'd6; lsb_cdb_val = 32'd2;
    tick();
    tick();
    chk("prio_en", 32'(alu_en), 32'd1);
    chk("prio_val1", alu_val1, 32'd1);

    // Fill all entries waiting on tag 9, then drain in index order.
    for (int i = 0; i < N; i++) begin
      dsp(OP_ADD, 3'd0, 1'b0, 1'b0, 32'd0, 4'd9, 1'b1, 32'(i), 4'd0, 32'd0, 32'h3000 + 32'(4 * i), 4'(i));
      tick();
    end
    chk("fill_full", 32'(rs_full), 32'd1);
    alu_cdb_en = 1'b1; alu_cdb_pos = 4'd9; alu_cdb_val = 32'h99;
    tick();
    chk("fill_full_after_wake", 32'(rs_full), 32'd1);
    tick();
    chk("fill_full_after_issue", 32'(rs_full), 32'd0);
    chk("fill_first_rob", 32'(alu_rob_pos), 32'd0);
    repeat (N - 1) tick();
    chk("fill_last_rob", 32'(alu_rob_pos), 32'd15);
    tick();
    chk("fill_done_en", 32'(alu_en), 32'd0);

    // Rollback with four waiting entries and an issue pending.
    for (int i = 0; i < 4; i++) begin
      dsp(OP_ADD, 3'd0, 1'b0, 1'b0, 32'd0, 4'd11, 1'b1, 32'd0, 4'd0, 32'd0, 32'h4000, 4'(8 + i));
      tick();
    end
    dsp(OP_ADDI, 3'd0, 1'b0, 1'b1, 32'd4, 4'd0, 1'b1, 32'd0, 4'd0, 32'd4, 32'h4010, 4'd12);
    tick();
    repeat (BYP ? 0 : 1) tick();
    chk("rb_pending_en", 32'(alu_en), 32'd1);
    rollback = 1'b1;
    dsp(OP_ADDI, 3'd0, 1'b0, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0, 32'd5, 32'h4014, 4'd13);
    alu_cdb_en = 1'b1; alu_cdb_pos = 4'd11; alu_cdb_val = 32'h55;
    tick();
    chk("rb_alu_en", 32'(alu_en), 32'd0);
    alu_cdb_en = 1'b1; alu_cdb_pos = 4'd11; alu_cdb_val = 32'h55;
    tick();
    tick();
    chk("rb_no_stale_issue", 32'(alu_en), 32'd0);

    // rdy low for three edges with an issue pending.
    dsp(OP_ADDI, 3'd0, 1'b0, 1'b1, 32'd21, 4'd0, 1'b1, 32'd0, 4'd0, 32'd1, 32'h5000, 4'd1);
    tick();
    dsp(OP_ADDI, 3'd0, 1'b0, 1'b1, 32'd22, 4'd0, 1'b1, 32'd0, 4'd0, 32'd2, 32'h5004, 4'd2);
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_en", 32'(alu_en), 32'd1);
      chk("hold_rob", 32'(alu_rob_pos), BYP ? 32'd2 : 32'd1);
    end
    rdy = 1'b1;
    tick();
    chk("release_en", 32'(alu_en), 32'(!BYP));
    chk("release_rob", 32'(alu_rob_pos), 32'd2);
    tick();
    chk("release_idle", 32'(alu_en), 32'd0);

    // Ready lui into an empty station.
    dsp(OP_LUI, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0, 32'habcde000, 32'h6000, 4'd7);
    tick();
    chk("lui_en_first_edge", 32'(alu_en), 32'(BYP));
    tick();
    chk("lui_en_second_edge", 32'(alu_en), 32'(!BYP));
    chk("lui_imm", alu_imm, 32'habcde000);
    chk("lui_rob", 32'(alu_rob_pos), 32'd7);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 7) != 0);
      rollback = ($urandom_range(0, 59) == 0);
      if (m_count() < N && $urandom_range(0, 1) == 1)
        dsp(7'($urandom), 3'($urandom), 1'($urandom),
            1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 7)),
            $urandom, $urandom, 4'($urandom));
      alu_cdb_en = ($urandom_range(0, 9) < 4);
      alu_cdb_pos = 4'($urandom_range(0, 7));
      alu_cdb_val = $urandom;
      lsb_cdb_en = ($urandom_range(0, 9) < 4);
      lsb_cdb_pos = 4'($urandom_range(0, 7));
      lsb_cdb_val = $urandom;
      tick();
    end

    // Drain: broadcast every tag, then let the station empty.
    rdy = 1'b1;
    for (int t = 0; t < N; t++) begin
      alu_cdb_en = 1'b1; alu_cdb_pos = 4'(t); alu_cdb_val = $urandom;
      tick();
    end
    repeat (N + 8) tick();
    chk("drain_rs_full", 32'(rs_full), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
